// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes,
// transmitter state encoding and the parity helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam int unsigned MAX_DATA_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Data is zero-extended to MAX_DATA_W; zero padding does not change the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input int unsigned mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and ready; head word is
// presented combinationally on head_c.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_c,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && ready;
  assign do_pop  = pop && (count != '0);
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      ready <= (count_next < CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words queue in a sync_fifo and are sent as
// start / data (LSB first) / optional parity / stop frames on pin.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          tx_en,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          pin,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_W + 1);

  tx_state_e          state;
  tx_state_e          state_n;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [BAUD_W-1:0]  baud_n;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   bit_n;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  shreg_n;
  logic               par_q;
  logic               par_n;
  logic               pin_n;
  logic               pop;
  logic               last_tick;
  logic               can_pop;
  logic               head_par;
  logic [DATA_W-1:0]  head;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (in_valid),
    .wdata  (in_data),
    .pop    (pop),
    .head_c (head),
    .ready  (in_ready),
    .count  (fifo_count)
  );

  assign last_tick = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign can_pop   = tx_en && (fifo_count != '0);
  assign head_par  = parity_bit(MAX_DATA_W'(head), PARITY);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      pin      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      par_q    <= par_n;
      pin      <= pin_n;
      busy     <= (state_n != ST_IDLE);
    end
  end

  // pin is registered from the next-state decision so each bit lines up
  // with the edge that enters its state.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt + BAUD_W'(1);
    bit_n   = bit_cnt;
    shreg_n = shreg;
    par_n   = par_q;
    pin_n   = pin;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_n = '0;
        pin_n  = 1'b1;
        if (can_pop) begin
          pop     = 1'b1;
          shreg_n = head;
          par_n   = head_par;
          state_n = ST_START;
          pin_n   = 1'b0;
        end
      end
      ST_START: begin
        if (last_tick) begin
          state_n = ST_DATA;
          baud_n  = '0;
          bit_n   = '0;
          pin_n   = shreg[0];
        end
      end
      ST_DATA: begin
        if (last_tick) begin
          baud_n = '0;
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            bit_n = '0;
            if (PARITY != PAR_NONE) begin
              state_n = ST_PARITY;
              pin_n   = par_q;
            end else begin
              state_n = ST_STOP;
              pin_n   = 1'b1;
            end
          end else begin
            bit_n   = bit_cnt + BIT_W'(1);
            shreg_n = shreg >> 1;
            pin_n   = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (last_tick) begin
          state_n = ST_STOP;
          baud_n  = '0;
          bit_n   = '0;
          pin_n   = 1'b1;
        end
      end
      ST_STOP: begin
        if (last_tick) begin
          baud_n = '0;
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            bit_n = '0;
            if (can_pop) begin
              pop     = 1'b1;
              shreg_n = head;
              par_n   = head_par;
              state_n = ST_START;
              pin_n   = 1'b0;
            end else begin
              state_n = ST_IDLE;
              pin_n   = 1'b1;
            end
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        baud_n  = '0;
        pin_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: four transmitter configurations driven in lockstep
// and compared each cycle against a frame-level reference model.
module tb_uart_tx_fifo;

  localparam int unsigned NCH   = 4;
  localparam int unsigned C     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DWS   [NCH] = '{8, 8, 8, 5};
  localparam int unsigned PARS  [NCH] = '{0, 1, 2, 0};
  localparam int unsigned STOPS [NCH] = '{1, 1, 1, 2};
  localparam int          FLS   [NCH] = '{40, 44, 44, 32};

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic tx_en  = 1'b0;
  logic [NCH-1:0] in_valid = '0;
  logic [NCH-1:0] in_ready;
  logic [NCH-1:0] pin;
  logic [NCH-1:0] busy;
  logic [8:0]     in_data    [NCH];
  logic [2:0]     fifo_count [NCH];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCH; g++) begin : g_dut
    uart_tx_fifo #(
      .DATA_W       (DWS[g]),
      .CLKS_PER_BIT (C),
      .PARITY       (PARS[g]),
      .STOP_BITS    (STOPS[g]),
      .FIFO_DEPTH   (DEPTH)
    ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .tx_en      (tx_en),
      .in_data    (in_data[g][DWS[g]-1:0]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .pin        (pin[g]),
      .busy       (busy[g]),
      .fifo_count (fifo_count[g])
    );
  end

  int n_err = 0;
  int n_chk = 0;

  // Reference model state: a word queue plus cycles remaining in the frame.
  int         rem  [NCH];
  int         cnt  [NCH];
  int         hd   [NCH];
  int         tl   [NCH];
  logic [8:0] cur  [NCH];
  logic [8:0] mbuf [NCH][8];
  bit         rdy  [NCH];
  bit         acc  [NCH];
  int         want [NCH];
  bit         use_fixed = 1'b0;
  logic [8:0] fixed [NCH] = '{9'h0A5, 9'h007, 9'h007, 9'h015};
  int         bcnt [NCH];
  int         rises[NCH];
  bit         prev_busy[NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_len(input int ch);
    return (1 + int'(DWS[ch]) + ((PARS[ch] != 0) ? 1 : 0) + int'(STOPS[ch])) * int'(C);
  endfunction

  function automatic logic [8:0] dmask(input int ch);
    logic [9:0] one;
    one = 10'd1;
    return 9'((one << DWS[ch]) - 10'd1);
  endfunction

  function automatic logic exp_bit(input int ch, input logic [8:0] w, input int k);
    int idx;
    idx = k / int'(C);
    if (idx == 0) return 1'b0;
    if (idx <= int'(DWS[ch])) return w[idx-1];
    if (PARS[ch] != 0 && idx == int'(DWS[ch]) + 1) return (^w) ^ (PARS[ch] == 2);
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      rem[ch] = 0; cnt[ch] = 0; hd[ch] = 0; tl[ch] = 0;
      cur[ch] = '0; rdy[ch] = 1'b0; acc[ch] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int ch = 0; ch < NCH; ch++) begin
      bit push, pop;
      push = in_valid[ch] && rdy[ch];
      pop  = 1'b0;
      if (rem[ch] <= 1) begin
        if (tx_en && cnt[ch] > 0) begin
          cur[ch] = mbuf[ch][hd[ch] % 8];
          hd[ch]++;
          pop = 1'b1;
          rem[ch] = frame_len(ch);
        end else begin
          rem[ch] = 0;
        end
      end else begin
        rem[ch]--;
      end
      if (push) begin
        mbuf[ch][tl[ch] % 8] = in_data[ch] & dmask(ch);
        tl[ch]++;
      end
      cnt[ch] = cnt[ch] + (push ? 1 : 0) - (pop ? 1 : 0);
      rdy[ch] = (cnt[ch] < int'(DEPTH));
      acc[ch] = push;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else         model_step();
    end
  end

  task automatic compare_all();
    for (int ch = 0; ch < NCH; ch++) begin
      logic ep;
      ep = (rem[ch] == 0) ? 1'b1 : exp_bit(ch, cur[ch], frame_len(ch) - rem[ch]);
      check($sformatf("pin%0d", ch),   32'(pin[ch]),        32'(ep));
      check($sformatf("busy%0d", ch),  32'(busy[ch]),       32'(rem[ch] != 0));
      check($sformatf("count%0d", ch), 32'(fifo_count[ch]), 32'(cnt[ch]));
      check($sformatf("ready%0d", ch), 32'(in_ready[ch]),   32'(rdy[ch]));
    end
  endtask

  task automatic drive();
    for (int ch = 0; ch < NCH; ch++) begin
      if (in_valid[ch] && acc[ch]) want[ch]--;
      if (want[ch] > 0) begin
        if (!in_valid[ch] || acc[ch])
          in_data[ch] = use_fixed ? fixed[ch] : 9'($urandom);
        in_valid[ch] = 1'b1;
      end else begin
        in_valid[ch] = 1'b0;
      end
      acc[ch] = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    for (int ch = 0; ch < NCH; ch++) begin
      if (busy[ch]) bcnt[ch]++;
      if (busy[ch] && !prev_busy[ch]) rises[ch]++;
      prev_busy[ch] = busy[ch];
    end
    drive();
  endtask

  task automatic clear_stats();
    for (int ch = 0; ch < NCH; ch++) begin
      bcnt[ch] = 0; rises[ch] = 0; prev_busy[ch] = busy[ch];
    end
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic reset_pulse(input string tag);
    resetn = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      want[ch] = 0;
      in_valid[ch] = 1'b0;
    end
    #1;
    check({tag, "_pin"},   32'(pin),      32'hF);
    check({tag, "_busy"},  32'(busy),     32'h0);
    check({tag, "_ready"}, 32'(in_ready), 32'h0);
    for (int ch = 0; ch < NCH; ch++)
      check($sformatf("%s_count%0d", tag, ch), 32'(fifo_count[ch]), 32'h0);
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    for (int ch = 0; ch < NCH; ch++) begin
      in_data[ch] = '0; want[ch] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_pin",   32'(pin),      32'hF);
    check("rst_busy",  32'(busy),     32'h0);
    check("rst_ready", 32'(in_ready), 32'h0);
    resetn = 1'b1;
    tick();
    check("ready_after_rst", 32'(in_ready), 32'hF);

    // Single fixed word per channel: 0xA5 / 0x07 even / 0x07 odd / 5-bit two-stop.
    tx_en = 1'b1;
    use_fixed = 1'b1;
    for (int ch = 0; ch < NCH; ch++) want[ch] = 1;
    drive();
    clear_stats();
    repeat (50) tick();
    for (int ch = 0; ch < NCH; ch++) begin
      check($sformatf("frame_len%0d", ch), 32'(bcnt[ch]), 32'(FLS[ch]));
      check($sformatf("frame_cnt%0d", ch), 32'(rises[ch]), 32'd1);
    end
    use_fixed = 1'b0;

    // Fill while disabled: fifth word must be held off, then back-to-back frames.
    tx_en = 1'b0;
    for (int ch = 0; ch < NCH; ch++) want[ch] = 5;
    drive();
    repeat (8) tick();
    for (int ch = 0; ch < NCH; ch++) begin
      check($sformatf("full_count%0d", ch), 32'(fifo_count[ch]), 32'd4);
      check($sformatf("full_ready%0d", ch), 32'(in_ready[ch]),   32'd0);
    end
    tx_en = 1'b1;
    clear_stats();
    repeat (5 * 44 + 20) tick();
    for (int ch = 0; ch < NCH; ch++) begin
      check($sformatf("burst_busy%0d", ch),  32'(bcnt[ch]),  32'(5 * FLS[ch]));
      check($sformatf("burst_rises%0d", ch), 32'(rises[ch]), 32'd1);
    end

    // Drop tx_en during data bit 2 with words still queued.
    for (int ch = 0; ch < NCH; ch++) want[ch] = 3;
    drive();
    repeat (14) tick();
    tx_en = 1'b0;
    repeat (60) tick();
    for (int ch = 0; ch < NCH; ch++) begin
      check($sformatf("hold_count%0d", ch), 32'(fifo_count[ch]), 32'd2);
      check($sformatf("hold_busy%0d", ch),  32'(busy[ch]),       32'd0);
    end

    // Reset during data bit 3.
    tx_en = 1'b1;
    for (int ch = 0; ch < NCH; ch++) want[ch] = 3;
    drive();
    repeat (18) tick();
    reset_pulse("midframe");
    tick();
    check("ready_after_pulse", 32'(in_ready), 32'hF);

    // Randomized traffic with enable toggling and rare resets.
    for (int i = 0; i < 3000; i++) begin
      if (tx_en ? ($urandom_range(39) == 0) : ($urandom_range(7) == 0))
        tx_en = ~tx_en;
      for (int ch = 0; ch < NCH; ch++)
        if (want[ch] == 0 && $urandom_range(3) == 0)
          want[ch] = int'($urandom_range(3, 1));
      drive();
      tick();
      if ($urandom_range(999) == 0) reset_pulse("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
